// File: rtl/dec_to_bin.sv
// Sequential BCD-to-binary converter: one digit per clock, most significant first,
// accumulating acc*10 + digit. Invalid digits are flagged and oversized results saturate.
module dec_to_bin #(
  parameter int NUM_DIGITS = 6,
  parameter int OUT_W      = 18
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    start_i,
  input  logic [4*NUM_DIGITS-1:0] bcd_in_i,
  output logic [OUT_W-1:0]        bin_18_o,
  output logic                    busy_o,
  output logic                    done_o,
  output logic                    err_o,
  output logic                    ovf_o
);

  localparam int ACC_W = 4 * NUM_DIGITS;
  localparam int CNT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    CONV,
    DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ACC_W-1:0]  shadow_q, shadow_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [CNT_W-1:0]  digitCnt_q, digitCnt_d;
  logic              invalid_q, invalid_d;
  logic [OUT_W-1:0]  bin_q, bin_d;
  logic              err_q, err_d;
  logic              ovf_q, ovf_d;

  logic [ACC_W-1:0]  shiftedShadow;
  logic [3:0]        digit;
  logic [ACC_W-1:0]  accNext;
  logic              invalidNext;
  logic              tooBig;

  // Current digit is picked from the latched copy, so bcd_in changes mid-conversion are ignored.
  assign shiftedShadow = shadow_q >> {digitCnt_q, 2'b00};
  assign digit         = shiftedShadow[3:0];
  assign accNext       = (acc_q << 3) + (acc_q << 1) + ACC_W'(digit);
  assign invalidNext   = invalid_q | (digit > 4'd9);
  assign tooBig        = (accNext >> OUT_W) != '0;

  always_comb begin
    state_d    = state_q;
    shadow_d   = shadow_q;
    acc_d      = acc_q;
    digitCnt_d = digitCnt_q;
    invalid_d  = invalid_q;
    bin_d      = bin_q;
    err_d      = err_q;
    ovf_d      = ovf_q;

    case (state_q)
      IDLE, DONE: begin
        if (start_i) begin
          state_d    = CONV;
          shadow_d   = bcd_in_i;
          acc_d      = '0;
          digitCnt_d = LAST_IDX;
          invalid_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      CONV: begin
        acc_d      = accNext;
        invalid_d  = invalidNext;
        digitCnt_d = digitCnt_q - 1'b1;
        // Result registers load only on the edge that consumes digit 0.
        if (digitCnt_q == '0) begin
          state_d = DONE;
          if (invalidNext) begin
            bin_d = '0;
            err_d = 1'b1;
            ovf_d = 1'b0;
          end else if (tooBig) begin
            bin_d = '1;
            err_d = 1'b0;
            ovf_d = 1'b1;
          end else begin
            bin_d = OUT_W'(accNext);
            err_d = 1'b0;
            ovf_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      shadow_q   <= '0;
      acc_q      <= '0;
      digitCnt_q <= '0;
      invalid_q  <= 1'b0;
      bin_q      <= '0;
      err_q      <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      shadow_q   <= shadow_d;
      acc_q      <= acc_d;
      digitCnt_q <= digitCnt_d;
      invalid_q  <= invalid_d;
      bin_q      <= bin_d;
      err_q      <= err_d;
      ovf_q      <= ovf_d;
    end
  end

  assign busy_o   = (state_q == CONV);
  assign done_o   = (state_q == DONE);
  assign bin_18_o = bin_q;
  assign err_o    = err_q;
  assign ovf_o    = ovf_q;

endmodule

// File: tb/tb_dec_to_bin.sv
// Scoreboard bench for dec_to_bin: stimulus pushes the arithmetic-model result,
// a monitor pops and compares on every done pulse and checks held outputs otherwise.
module tb_dec_to_bin;

  localparam int NUM_DIGITS = 6;
  localparam int OUT_W      = 18;
  localparam int MAX_OUT    = (1 << OUT_W) - 1;

  typedef struct {
    logic [OUT_W-1:0] bin;
    logic             err;
    logic             ovf;
  } exp_t;

  logic                    clk_i = 1'b0;
  logic                    rst_i = 1'b0;
  logic                    start_i = 1'b0;
  logic [4*NUM_DIGITS-1:0] bcd_in_i = '0;
  logic [OUT_W-1:0]        bin_18_o;
  logic                    busy_o;
  logic                    done_o;
  logic                    err_o;
  logic                    ovf_o;

  exp_t expQ[$];
  exp_t held;
  bit   monitorOn = 1'b0;
  int   nCompared = 0;
  int   nMismatched = 0;

  dec_to_bin #(.NUM_DIGITS(NUM_DIGITS), .OUT_W(OUT_W)) dut (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .start_i (start_i),
    .bcd_in_i(bcd_in_i),
    .bin_18_o(bin_18_o),
    .busy_o  (busy_o),
    .done_o  (done_o),
    .err_o   (err_o),
    .ovf_o   (ovf_o)
  );

  always #5 clk_i = ~clk_i;

  // Decimal value from the digits by place value; any digit above 9 marks it invalid.
  function automatic exp_t model(input logic [4*NUM_DIGITS-1:0] bcd);
    exp_t        r;
    longint      value = 0;
    longint      place = 1;
    bit          bad = 1'b0;
    int          d;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      d = int'(bcd[4*i +: 4]);
      if (d > 9) bad = 1'b1;
      value += d * place;
      place *= 10;
    end
    if (bad) begin
      r.bin = '0; r.err = 1'b1; r.ovf = 1'b0;
    end else if (value > MAX_OUT) begin
      r.bin = '1; r.err = 1'b0; r.ovf = 1'b1;
    end else begin
      r.bin = OUT_W'(value); r.err = 1'b0; r.ovf = 1'b0;
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    nCompared++;
    if (actual !== required) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, actual, required, $time);
    end
  endtask

  // A reset edge discards any pending result and clears the held outputs.
  always @(posedge clk_i) begin
    if (rst_i) begin
      expQ.delete();
      held.bin = '0;
      held.err = 1'b0;
      held.ovf = 1'b0;
    end
  end

  always @(negedge clk_i) begin
    if (monitorOn) begin
      if (done_o) begin
        if (expQ.size() == 0) begin
          checkOutput("unexpectedDone", 32'(done_o), 32'd0);
        end else begin
          held = expQ.pop_front();
          checkOutput("bin", 32'(bin_18_o), 32'(held.bin));
          checkOutput("err", 32'(err_o), 32'(held.err));
          checkOutput("ovf", 32'(ovf_o), 32'(held.ovf));
        end
      end else begin
        checkOutput("heldOutputs", {12'd0, ovf_o, err_o, bin_18_o}, {12'd0, held.ovf, held.err, held.bin});
      end
    end
  end

  task automatic applyStimulus(input logic [4*NUM_DIGITS-1:0] bcd);
    @(negedge clk_i);
    bcd_in_i = bcd;
    start_i  = 1'b1;
    expQ.push_back(model(bcd));
    @(posedge clk_i);
    #1 start_i = 1'b0;
  endtask

  task automatic waitDone(output int busyCnt);
    bit seen = 1'b0;
    busyCnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk_i);
      if (done_o) begin
        seen = 1'b1;
        break;
      end
      if (busy_o) busyCnt++;
    end
    if (!seen) checkOutput("doneTimeout", 32'd0, 32'd1);
  endtask

  task automatic convertAndCheck(input logic [4*NUM_DIGITS-1:0] bcd);
    int busyCnt;
    applyStimulus(bcd);
    waitDone(busyCnt);
    checkOutput("busyCycles", 32'(busyCnt), 32'(NUM_DIGITS));
    checkOutput("busyInDone", 32'(busy_o), 32'd0);
    @(negedge clk_i);
    checkOutput("donePulseWidth", 32'(done_o), 32'd0);
  endtask

  function automatic logic [4*NUM_DIGITS-1:0] randBcd();
    logic [4*NUM_DIGITS-1:0] v;
    int d;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if ($urandom_range(0, 11) == 0) d = int'($urandom_range(10, 15));
      else if (i == NUM_DIGITS - 1) d = int'($urandom_range(0, 3));
      else d = int'($urandom_range(0, 9));
      v[4*i +: 4] = 4'(d);
    end
    return v;
  endfunction

  initial begin
    int busyCnt;

    rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    checkOutput("resetBin", 32'(bin_18_o), 32'd0);
    checkOutput("resetFlags", {28'd0, busy_o, done_o, err_o, ovf_o}, 32'd0);
    monitorOn = 1'b1;
    rst_i = 1'b0;

    convertAndCheck(24'h123456);
    convertAndCheck(24'h262143);
    convertAndCheck(24'h262144);
    convertAndCheck(24'h999999);
    convertAndCheck(24'h00A000);
    convertAndCheck(24'h000000);

    // A second start during CONV must be ignored; then a start held in DONE chains directly.
    applyStimulus(24'h000042);
    @(negedge clk_i);
    bcd_in_i = 24'h999999;
    start_i  = 1'b1;
    @(posedge clk_i);
    #1 start_i = 1'b0;
    waitDone(busyCnt);
    bcd_in_i = 24'h000007;
    start_i  = 1'b1;
    expQ.push_back(model(24'h000007));
    @(posedge clk_i);
    #1 start_i = 1'b0;
    waitDone(busyCnt);
    checkOutput("chainedBusyCycles", 32'(busyCnt), 32'(NUM_DIGITS));
    repeat (3) @(negedge clk_i);

    // Reset on the third CONV cycle discards the conversion with no done pulse.
    applyStimulus(24'h123456);
    repeat (2) @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    @(posedge clk_i);
    #1;
    checkOutput("midResetBusy", 32'(busy_o), 32'd0);
    checkOutput("midResetDone", 32'(done_o), 32'd0);
    checkOutput("midResetBin", 32'(bin_18_o), 32'd0);
    rst_i = 1'b0;
    repeat (10) @(negedge clk_i);
    convertAndCheck(24'h000001);

    for (int n = 0; n < 30; n++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
      convertAndCheck(randBcd());
    end

    repeat (4) @(negedge clk_i);
    checkOutput("pendingResults", 32'(expQ.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/dec_to_bin.md
Name: dec_to_bin

Overview:
- Sequential BCD-to-binary converter. It is the inverse of the binary-to-decimal path that feeds the seven-segment digits.
- It takes NUM_DIGITS packed BCD digits (for example, values entered digit-by-digit from switches) and produces an OUT_W-bit binary value on the existing 18-bit datapath.
- It uses an iterative multiply-by-10-and-add over one digit per clock, with a start/busy/done handshake.
- It flags invalid BCD digits and results that overflow the output width.

Parameters:
- NUM_DIGITS, 6: number of BCD digits converted; digit index NUM_DIGITS-1 is most significant.
- OUT_W, 18: output binary width. Results above 2^OUT_W-1 saturate.

Ports:
- clk, input, 1: system clock; all state changes on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- start, input, 1: conversion request. Sampled only in IDLE or DONE.
- bcd_in, input, 4*NUM_DIGITS: packed digits. bits[3:0] = digit_1 (units) ... bits[23:20] = digit_6 at defaults.
- bin_18, output, OUT_W: converted result, registered, held until the next completion.
- busy, output, 1: high while converting.
- done, output, 1: single-cycle completion pulse.
- err, output, 1: last conversion saw a digit > 9. Held with bin_18.
- ovf, output, 1: last conversion exceeded 2^OUT_W-1. Held with bin_18.

Behaviour:
- Reset:
  - Synchronous reset, active-high, one clock.
  - rst=1 at an edge forces state=IDLE, bin_18=0, busy=0, done=0, err=0, ovf=0; the internal accumulator and counter are cleared.
  - rst overrides start and any conversion in flight. A mid-conversion reset discards the partial result; no done pulse follows.
- States: IDLE, CONV, DONE.
- IDLE:
  - busy=0, done=0.
  - start=1 at an edge → CONV, with these actions on the same edge:
    - bcd_in latched into an internal shadow register;
    - accumulator (width 4*NUM_DIGITS, enough for 10^NUM_DIGITS-1) cleared;
    - digit counter set to NUM_DIGITS-1;
    - invalid flag cleared.
- CONV:
  - busy=1.
  - Each edge: acc ← acc*10 + latched digit[counter]. Use acc*10 as (acc<<3)+(acc<<1); no multiplier inferred.
  - If the digit is > 9, set the sticky invalid flag. The digit value is still added; the result is discarded later.
  - Counter decrements. After the edge that processes digit 0 (NUM_DIGITS edges after entry), go to DONE.
  - On that same final edge, register the outputs. Priority:
    - invalid set → bin_18=0, err=1, ovf=0;
    - else final acc > 2^OUT_W-1 → bin_18=all ones, ovf=1, err=0;
    - else bin_18=acc[OUT_W-1:0], err=0, ovf=0.
  - start is ignored in CONV. bcd_in changes after the latch edge have no effect.
- DONE:
  - done=1 and busy=0 for exactly this one cycle.
  - start=1 at the DONE edge → CONV, with the same latch actions as IDLE (back-to-back conversions allowed).
  - Otherwise → IDLE.
- Latency:
  - Start sampled at edge k → busy high cycles k+1..k+NUM_DIGITS.
  - bin_18/err/ovf update at edge k+NUM_DIGITS.
  - done high for the single cycle after edge k+NUM_DIGITS (6 clocks at default).
  - Back-to-back throughput: one result per NUM_DIGITS+1 clocks.
- Output holding: bin_18, err and ovf change only at a completion edge or at reset.

Test Plan:
- Reset, then bcd_in=0x123456, start pulse 1 cycle → done after 6 clocks; bin_18=123456 (0x1E240), err=0, ovf=0; busy high exactly 6 cycles; done high exactly 1 cycle.
- bcd_in=0x262143 → bin_18=0x3FFFF, ovf=0. Then bcd_in=0x262144 → bin_18=0x3FFFF, ovf=1. Then bcd_in=0x999999 → bin_18=0x3FFFF, ovf=1.
- bcd_in=0x00A000 → err=1, ovf=0, bin_18=0. Then bcd_in=0x000000 → err=0, bin_18=0.
- Start convert of 0x000042; during CONV change bcd_in to 0x999999 and pulse start again.
  - Required: second start ignored; bin_18=42; a single done pulse.
  - Then hold start=1 in the DONE cycle with bcd_in=0x000007 → new conversion begins at once; bin_18=7 after 6 more clocks.
- Start convert of 0x123456; assert rst for 1 cycle on the third CONV cycle → busy=0, done=0, bin_18=0 next cycle, and no done pulse follows.
  - A fresh start with 0x000001 then yields bin_18=1 with normal latency.
